// File: rtl/switch_port_rx_if.sv
// Byte-stream bus from a switch output port plus the FIFO read side and
// the decoded header and status outputs of switch_port_rx.
interface switch_port_rx_if;
  logic        valid_op;
  logic [7:0]  data_op;
  logic        suspend_ip;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_empty;
  logic        hdr_valid;
  logic [3:0]  hdr_source;
  logic [3:0]  hdr_target;
  logic [7:0]  hdr_len;
  logic [1:0]  hdr_ptype;
  logic        pkt_done;
  logic [3:0]  pkt_err;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  modport slave (
    input  valid_op, data_op, rd_en,
    output suspend_ip, rd_data, rd_empty, hdr_valid, hdr_source, hdr_target,
           hdr_len, hdr_ptype, pkt_done, pkt_err, pkt_count, err_count
  );

  modport master (
    output valid_op, data_op, rd_en,
    input  suspend_ip, rd_data, rd_empty, hdr_valid, hdr_source, hdr_target,
           hdr_len, hdr_ptype, pkt_done, pkt_err, pkt_count, err_count
  );
endinterface

// File: rtl/switch_port_rx.sv
// Receive side of a switch port: parses {target,source},length,payload packets,
// buffers the payload in a show-ahead FIFO and reports header fields and errors.
module switch_port_rx #(
  parameter int DEPTH = 16
) (
  input logic             clk,
  input logic             reset,
  switch_port_rx_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      tgt_q, tgt_d;
  logic [3:0]      src_q, src_d;
  logic [7:0]      remain_q, remain_d;
  logic [2:0]      hdr_err_q, hdr_err_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            suspend_q, suspend_d;

  logic            hdr_valid_q, hdr_valid_d;
  logic [3:0]      hdr_source_q, hdr_source_d;
  logic [3:0]      hdr_target_q, hdr_target_d;
  logic [7:0]      hdr_len_q, hdr_len_d;
  logic [1:0]      hdr_ptype_q, hdr_ptype_d;
  logic            pkt_done_q, pkt_done_d;
  logic [3:0]      pkt_err_q, pkt_err_d;
  logic [15:0]     pkt_count_q, pkt_count_d;
  logic [15:0]     err_count_q, err_count_d;

  logic            pop, push, drop, full, pay_wr;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [1:0] classify(input logic [3:0] tgt);
    if (tgt == 4'hF)               return 2'b10;
    else if (popcount4(tgt) == 3'd1) return 2'b00;
    else                           return 2'b01;
  endfunction

  // Bits [2:0] of pkt_err; the overflow bit is accumulated during the payload.
  function automatic logic [2:0] header_err(input logic [3:0] src,
                                            input logic [3:0] tgt,
                                            input logic [7:0] len);
    logic [2:0] e;
    e[0] = (popcount4(src) != 3'd1);
    e[1] = (tgt == 4'h0) || ((tgt != 4'hF) && ((src & tgt) != 4'h0));
    e[2] = (len == 8'd0);
    return e;
  endfunction

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    src_d        = src_q;
    remain_d     = remain_q;
    hdr_err_d    = hdr_err_q;
    ovf_d        = ovf_q;
    hdr_valid_d  = 1'b0;
    hdr_source_d = hdr_source_q;
    hdr_target_d = hdr_target_q;
    hdr_len_d    = hdr_len_q;
    hdr_ptype_d  = hdr_ptype_q;
    pkt_done_d   = 1'b0;
    pkt_err_d    = 4'h0;
    pkt_count_d  = pkt_count_q;
    err_count_d  = err_count_q;

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    full   = (count_q == CW'(DEPTH));
    pop    = bus.rd_en && (count_q != '0);
    pay_wr = (state_q == S_PAYLOAD) && bus.valid_op;
    push   = pay_wr && (!full || pop);
    drop   = pay_wr && full && !pop;

    unique case (state_q)
      S_IDLE: begin
        if (bus.valid_op) begin
          tgt_d   = bus.data_op[7:4];
          src_d   = bus.data_op[3:0];
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (bus.valid_op) begin
          hdr_valid_d  = 1'b1;
          hdr_source_d = src_q;
          hdr_target_d = tgt_q;
          hdr_len_d    = bus.data_op;
          hdr_ptype_d  = classify(tgt_q);
          hdr_err_d    = header_err(src_q, tgt_q, bus.data_op);
          ovf_d        = 1'b0;
          remain_d     = bus.data_op;
          if (bus.data_op == 8'd0) begin
            pkt_done_d = 1'b1;
            pkt_err_d  = {1'b0, header_err(src_q, tgt_q, bus.data_op)};
            state_d    = S_IDLE;
          end else begin
            state_d    = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.valid_op) begin
          remain_d = remain_q - 8'd1;
          ovf_d    = ovf_q | drop;
          if (remain_q == 8'd1) begin
            pkt_done_d = 1'b1;
            pkt_err_d  = {ovf_q | drop, hdr_err_q};
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pkt_done_d) begin
      pkt_count_d = sat_inc16(pkt_count_q);
      if (pkt_err_d != 4'h0) err_count_d = sat_inc16(err_count_q);
    end

    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    // Two slots of headroom cover the sender's one-cycle reaction to suspend.
    suspend_d = (count_d >= CW'(DEPTH - 2));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tgt_q        <= '0;
      src_q        <= '0;
      remain_q     <= '0;
      hdr_err_q    <= '0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      suspend_q    <= 1'b0;
      hdr_valid_q  <= 1'b0;
      hdr_source_q <= '0;
      hdr_target_q <= '0;
      hdr_len_q    <= '0;
      hdr_ptype_q  <= '0;
      pkt_done_q   <= 1'b0;
      pkt_err_q    <= '0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      src_q        <= src_d;
      remain_q     <= remain_d;
      hdr_err_q    <= hdr_err_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      suspend_q    <= suspend_d;
      hdr_valid_q  <= hdr_valid_d;
      hdr_source_q <= hdr_source_d;
      hdr_target_q <= hdr_target_d;
      hdr_len_q    <= hdr_len_d;
      hdr_ptype_q  <= hdr_ptype_d;
      pkt_done_q   <= pkt_done_d;
      pkt_err_q    <= pkt_err_d;
      pkt_count_q  <= pkt_count_d;
      err_count_q  <= err_count_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.data_op;
  end

  assign bus.rd_empty   = (count_q == '0);
  assign bus.rd_data    = (count_q == '0) ? 8'h00 : mem[rd_ptr_q];
  assign bus.suspend_ip = suspend_q;
  assign bus.hdr_valid  = hdr_valid_q;
  assign bus.hdr_source = hdr_source_q;
  assign bus.hdr_target = hdr_target_q;
  assign bus.hdr_len    = hdr_len_q;
  assign bus.hdr_ptype  = hdr_ptype_q;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.pkt_err    = pkt_err_q;
  assign bus.pkt_count  = pkt_count_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_switch_port_rx.sv
// Bench for switch_port_rx: directed packets plus randomized traffic checked
// cycle by cycle against a packet-level reference model.
module tb_switch_port_rx;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  switch_port_rx_if bus();

  switch_port_rx #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mq[$];
  logic [7:0]  pl[$];
  logic        pkt_ovf;
  logic [3:0]  cur_src, cur_tgt, cur_err;
  logic [7:0]  cur_len;
  logic [1:0]  cur_ptype;
  logic [3:0]  e_src, e_tgt;
  logic [7:0]  e_len;
  logic [1:0]  e_ptype;
  logic [15:0] e_pc, e_ec;
  logic [3:0]  last_err;
  int          done_seen;

  function automatic int pop4(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit exp_hv, input bit exp_pd);
    chk("rd_empty", 32'(bus.rd_empty), 32'(mq.size() == 0));
    if (mq.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(mq[0]));
    chk("suspend_ip", 32'(bus.suspend_ip), 32'(mq.size() >= DEPTH - 2));
    chk("hdr_valid", 32'(bus.hdr_valid), 32'(exp_hv));
    chk("pkt_done", 32'(bus.pkt_done), 32'(exp_pd));
    chk("hdr_source", 32'(bus.hdr_source), 32'(e_src));
    chk("hdr_target", 32'(bus.hdr_target), 32'(e_tgt));
    chk("hdr_len", 32'(bus.hdr_len), 32'(e_len));
    chk("hdr_ptype", 32'(bus.hdr_ptype), 32'(e_ptype));
    if (exp_pd) chk("pkt_err", 32'(bus.pkt_err), 32'(cur_err | {pkt_ovf, 3'b000}));
    chk("pkt_count", 32'(bus.pkt_count), 32'(e_pc));
    chk("err_count", 32'(bus.err_count), 32'(e_ec));
  endtask

  // One clock: drive inputs, advance the model across the edge, then check.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r,
                     input bit is_pay, input bit hv, input bit pd);
    bus.valid_op = v;
    bus.data_op  = d;
    bus.rd_en    = r;
    @(posedge clk);
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (v && is_pay) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else pkt_ovf = 1'b1;
    end
    if (hv) begin
      e_src = cur_src; e_tgt = cur_tgt; e_len = cur_len; e_ptype = cur_ptype;
    end
    if (pd) begin
      if (e_pc != 16'hFFFF) e_pc = e_pc + 16'd1;
      if ((cur_err | {pkt_ovf, 3'b000}) != 4'h0 && e_ec != 16'hFFFF) e_ec = e_ec + 16'd1;
    end
    #1;
    bus.valid_op = 1'b0;
    bus.rd_en    = 1'b0;
    check_outputs(hv, pd);
    if (pd) begin
      last_err = bus.pkt_err;
      done_seen++;
    end
  endtask

  // Sends b0, len and len payload bytes (taken from pl, topped up randomly).
  // limit >= 0 stops after that many bytes to leave a packet unfinished.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] len, input int gap_pct,
                          input int rd_pct, input bit honour, input int limit);
    logic [7:0] bytes[$];
    int nsend;
    cur_tgt   = b0[7:4];
    cur_src   = b0[3:0];
    cur_len   = len;
    cur_ptype = (cur_tgt == 4'hF) ? 2'b10 : (pop4(cur_tgt) == 1) ? 2'b00 : 2'b01;
    cur_err   = 4'h0;
    cur_err[0] = (pop4(cur_src) != 1);
    cur_err[1] = (cur_tgt == 4'h0) || (cur_tgt != 4'hF && (cur_src & cur_tgt) != 4'h0);
    cur_err[2] = (len == 8'd0);
    pkt_ovf   = 1'b0;
    while (pl.size() < int'(len)) pl.push_back(8'($urandom_range(0, 255)));
    bytes.push_back(b0);
    bytes.push_back(len);
    for (int i = 0; i < int'(len); i++) bytes.push_back(pl.pop_front());
    pl.delete();
    nsend = (limit < 0) ? bytes.size() : limit;
    for (int i = 0; i < nsend; i++) begin
      int stall = 0;
      while ((stall < 200) &&
             (($urandom_range(0, 99) < gap_pct) || (honour && bus.suspend_ip))) begin
        cyc(1'b0, 8'h00, ($urandom_range(0, 99) < rd_pct) || (stall > 8), 1'b0, 1'b0, 1'b0);
        stall++;
      end
      cyc(1'b1, bytes[i], $urandom_range(0, 99) < rd_pct, i >= 2, i == 1,
          (i == 1 && len == 8'd0) || (i >= 2 && i == bytes.size() - 1));
    end
  endtask

  task automatic drain();
    int k = 0;
    while (mq.size() > 0 && k < 300) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("drain_empty", 32'(bus.rd_empty), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.valid_op = 1'b0;
    bus.rd_en    = 1'b0;
    bus.data_op  = 8'h00;
    #2;
    mq.delete();
    e_src = '0; e_tgt = '0; e_len = '0; e_ptype = '0; e_pc = '0; e_ec = '0;
    chk("rst_rd_empty", 32'(bus.rd_empty), 32'd1);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_suspend", 32'(bus.suspend_ip), 32'd0);
    chk("rst_hdr_valid", 32'(bus.hdr_valid), 32'd0);
    chk("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
    chk("rst_pkt_err", 32'(bus.pkt_err), 32'd0);
    chk("rst_hdr", 32'({bus.hdr_source, bus.hdr_target, bus.hdr_len, bus.hdr_ptype}), 32'd0);
    chk("rst_counts", 32'({bus.pkt_count, bus.err_count}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    done_seen = 0;
    last_err  = '0;
    do_reset();

    // Single destination, payload popped in order.
    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(8'h21, 8'd3, 0, 0, 1'b0, -1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_src", 32'(bus.hdr_source), 32'd1);
    chk("single_tgt", 32'(bus.hdr_target), 32'd2);
    chk("single_len", 32'(bus.hdr_len), 32'd3);
    chk("single_ptype", 32'(bus.hdr_ptype), 32'd0);
    chk("single_err", 32'(last_err), 32'd0);
    chk("single_count", 32'(bus.pkt_count), 32'd1);
    chk("single_head", 32'(bus.rd_data), 32'hAA);
    drain();

    // Broadcast and multicast.
    pl = '{8'h55};
    send_pkt(8'hF4, 8'd1, 20, 30, 1'b0, -1);
    chk("bcast_ptype", 32'(bus.hdr_ptype), 32'd2);
    chk("bcast_err", 32'(last_err), 32'd0);
    pl = '{8'h00};
    send_pkt(8'h61, 8'd1, 20, 30, 1'b0, -1);
    chk("mcast_ptype", 32'(bus.hdr_ptype), 32'd1);
    chk("mcast_err", 32'(last_err), 32'd0);
    drain();

    // Bad headers.
    pl = '{8'h00};
    send_pkt(8'h33, 8'd1, 0, 0, 1'b0, -1);
    chk("bad_err", 32'(last_err), 32'h3);
    chk("bad_errcount", 32'(bus.err_count), 32'd1);
    send_pkt(8'h01, 8'd0, 0, 0, 1'b0, -1);
    chk("zero_err", 32'(last_err), 32'h6);
    chk("zero_errcount", 32'(bus.err_count), 32'd2);
    drain();

    // Backpressure with a sender that honours suspend_ip.
    send_pkt(8'h21, 8'd20, 0, 0, 1'b1, -1);
    chk("bp_err", 32'(last_err), 32'd0);
    drain();

    // Overflow: sender ignores suspend_ip, last two bytes dropped.
    for (int i = 1; i <= 18; i++) pl.push_back(8'(i));
    send_pkt(8'h21, 8'd18, 0, 0, 1'b0, -1);
    chk("ovf_err", 32'(last_err), 32'h8);
    chk("ovf_head", 32'(bus.rd_data), 32'd1);
    chk("ovf_suspend", 32'(bus.suspend_ip), 32'd1);
    drain();

    // Reset in the middle of a payload discards the packet.
    done_seen = 0;
    send_pkt(8'h21, 8'd5, 0, 0, 1'b0, 4);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_no_done", 32'(done_seen), 32'd0);
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(8'h42, 8'd4, 10, 0, 1'b0, -1);
    chk("post_rst_count", 32'(bus.pkt_count), 32'd1);
    chk("post_rst_head", 32'(bus.rd_data), 32'h11);
    drain();

    // Randomized traffic.
    for (int p = 0; p < 40; p++) begin
      send_pkt(8'($urandom_range(0, 255)), 8'($urandom_range(0, 40)),
               $urandom_range(0, 40), $urandom_range(0, 100), 1'($urandom_range(0, 1)), -1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
